// File: rtl/sm4_mask_pool.sv
// Mask randomness pool for the masked SM4 datapath: buffers 128-bit NLFR samples,
// drops stuck-source repeats and serves them as 32-bit words, MSB word first.
module sm4_mask_pool #(
  parameter int DEPTH     = 4,
  parameter int REP_LIMIT = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [127:0]               rnd_in,
  input  logic                       rnd_en,
  input  logic                       mask_ready,
  output logic                       mask_valid,
  output logic [31:0]                mask_out,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       rep_err,
  input  logic                       clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(REP_LIMIT + 1);

  logic [127:0]   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [1:0]     idx;
  logic [127:0]   last_sample;
  logic           last_ok;
  logic [RW-1:0]  rep_cnt;

  logic           xfer, pop, space, sample, is_rep, wr, rep_hit;
  logic [127:0]   head;

  assign mask_valid = (count != '0);
  assign xfer       = mask_valid & mask_ready;
  assign pop        = xfer & (idx == 2'd3);
  // A full FIFO can still accept a sample when its head leaves on this edge.
  assign space      = (count < CW'(DEPTH)) | pop;
  assign sample     = rnd_en & ~rep_err & space;
  assign is_rep     = last_ok & (rnd_in == last_sample);
  assign wr         = sample & ~is_rep;
  assign rep_hit    = sample & is_rep & (rep_cnt == RW'(REP_LIMIT - 1));
  assign fill_level = count;

  always_comb begin
    head     = mem[rd_ptr];
    mask_out = '0;
    if (mask_valid) begin
      case (idx)
        2'd0:    mask_out = head[127:96];
        2'd1:    mask_out = head[95:64];
        2'd2:    mask_out = head[63:32];
        default: mask_out = head[31:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      idx    <= '0;
    end else begin
      // Clear before write so a same-slot write on a full FIFO wins.
      if (pop) mem[rd_ptr] <= '0;
      if (wr) begin
        mem[wr_ptr] <= rnd_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (xfer) idx <= idx + 2'd1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_sample <= '0;
      last_ok     <= 1'b0;
      rep_cnt     <= '0;
      rep_err     <= 1'b0;
    end else begin
      if (sample) begin
        last_sample <= rnd_in;
        last_ok     <= 1'b1;
        if (is_rep) begin
          if (rep_cnt != RW'(REP_LIMIT)) rep_cnt <= rep_cnt + 1'b1;
        end else begin
          rep_cnt <= '0;
        end
        if (rep_hit) rep_err <= 1'b1;
      end
      if (clr_err) begin
        rep_err <= 1'b0;
        rep_cnt <= '0;
        last_ok <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sm4_mask_pool.sv
// Directed self-checking bench for sm4_mask_pool (DEPTH=4, REP_LIMIT=3).
module tb_sm4_mask_pool;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] rnd_in;
  logic         rnd_en;
  logic         mask_ready;
  logic         mask_valid;
  logic [31:0]  mask_out;
  logic [2:0]   fill_level;
  logic         rep_err;
  logic         clr_err;

  int n_assert = 0;
  int n_fail   = 0;

  sm4_mask_pool #(.DEPTH(4), .REP_LIMIT(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rnd_in     (rnd_in),
    .rnd_en     (rnd_en),
    .mask_ready (mask_ready),
    .mask_valid (mask_valid),
    .mask_out   (mask_out),
    .fill_level (fill_level),
    .rep_err    (rep_err),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int k, input int j);
    return 32'h5A00_0000 | 32'(k << 8) | 32'(j);
  endfunction

  function automatic logic [127:0] smp(input int k);
    return {word(k, 0), word(k, 1), word(k, 2), word(k, 3)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rnd_in = '0; rnd_en = 1'b0; mask_ready = 1'b0; clr_err = 1'b0;
    tick(); tick();
    chk("rst_valid", mask_valid, 0);
    chk("rst_out",   mask_out,   0);
    chk("rst_fill",  fill_level, 0);
    chk("rst_err",   rep_err,    0);
    rst_n = 1'b1;
    tick();

    // 1: two samples streamed straight out
    rnd_en = 1'b1; mask_ready = 1'b1; rnd_in = smp(1);
    tick();
    chk("t1_fill1", fill_level, 1);
    chk("t1_A0", mask_out, word(1, 0));
    rnd_in = smp(2);
    tick();
    rnd_en = 1'b0;
    chk("t1_fill2", fill_level, 2);
    chk("t1_A1", mask_out, word(1, 1));
    tick(); chk("t1_A2", mask_out, word(1, 2));
    tick(); chk("t1_A3", mask_out, word(1, 3));
    tick(); chk("t1_B0", mask_out, word(2, 0));
    chk("t1_fill_pop", fill_level, 1);
    tick(); chk("t1_B1", mask_out, word(2, 1));
    tick(); chk("t1_B2", mask_out, word(2, 2));
    tick(); chk("t1_B3", mask_out, word(2, 3));
    tick();
    chk("t1_empty_valid", mask_valid, 0);
    chk("t1_empty_out",   mask_out,   0);
    chk("t1_empty_fill",  fill_level, 0);

    // 2: fill with ready low, 6 samples offered, last two lost
    mask_ready = 1'b0; rnd_en = 1'b1;
    for (int k = 3; k <= 8; k++) begin
      rnd_in = smp(k);
      tick();
    end
    rnd_en = 1'b0;
    chk("t2_fill", fill_level, 4);
    chk("t2_valid", mask_valid, 1);

    // 3: pop on idx3 coincides with a new sample C while full
    mask_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("t2_s3w%0d", j), mask_out, word(3, j));
      if (j == 3) begin
        rnd_en = 1'b1; rnd_in = smp(9);
      end
      tick();
    end
    rnd_en = 1'b0;
    chk("t3_fill", fill_level, 4);
    for (int k = 4; k <= 7; k++) begin
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("t3_s%0dw%0d", (k == 7) ? 9 : k, j), mask_out, word((k == 7) ? 9 : k, j));
        tick();
      end
    end
    chk("t3_empty_valid", mask_valid, 0);
    chk("t3_empty_fill",  fill_level, 0);

    // 4: stuck source
    mask_ready = 1'b0; rnd_en = 1'b1; rnd_in = smp(11);
    tick(); chk("t4_fill_x", fill_level, 1);
    tick(); tick();
    chk("t4_err_3", rep_err, 0);
    tick(); chk("t4_err_4", rep_err, 1);
    tick();
    chk("t4_err_5", rep_err, 1);
    chk("t4_fill_hold", fill_level, 1);
    rnd_en = 1'b0; clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t4_clr", rep_err, 0);
    rnd_en = 1'b1; rnd_in = smp(11);
    tick(); chk("t4_fill_x2", fill_level, 2);
    rnd_in = smp(12);
    tick(); chk("t4_fill_y", fill_level, 3);
    rnd_en = 1'b0;

    // 6: async reset mid-drain with 3 entries
    mask_ready = 1'b1;
    tick();
    chk("t6_pre_out", mask_out, word(11, 1));
    chk("t6_pre_fill", fill_level, 3);
    mask_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", mask_valid, 0);
    chk("t6_out",   mask_out,   0);
    chk("t6_fill",  fill_level, 0);
    chk("t6_err",   rep_err,    0);
    tick();
    rst_n = 1'b1;
    tick();

    // 5: backpressure 1,0,0,1
    rnd_en = 1'b1; rnd_in = smp(10);
    tick();
    rnd_en = 1'b0;
    chk("t5_w0", mask_out, word(10, 0));
    mask_ready = 1'b1; tick(); chk("t5_r1", mask_out, word(10, 1));
    mask_ready = 1'b0; tick(); chk("t5_r0a", mask_out, word(10, 1));
    mask_ready = 1'b0; tick(); chk("t5_r0b", mask_out, word(10, 1));
    chk("t5_valid_hold", mask_valid, 1);
    mask_ready = 1'b1; tick(); chk("t5_r1b", mask_out, word(10, 2));
    tick(); chk("t5_w3", mask_out, word(10, 3));
    tick();
    chk("t5_empty", mask_valid, 0);
    chk("t5_fill", fill_level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
